// File: rtl/adder_subtractor_reg.sv
// Registered unsigned adder/subtractor with (WIDTH+1)-bit result and sign/zero flags.
// Define ADDSUB_PIPE_EN to add an input register stage (2-cycle latency instead of 1).
module adder_subtractor_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic             subtract_mode,
  input  logic             in_valid,
  output logic [WIDTH:0]   result,
  output logic             out_valid,
  output logic             negative,
  output logic             zero
);

  // One ripple cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    full_add = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic             mode_s;
  logic             valid_s;

`ifdef ADDSUB_PIPE_EN
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             mode_r;
  logic             valid_r;

  // Input stage: operands load only with valid; clearing valid_r drops any in-flight op on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      mode_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= in_valid;
      if (in_valid) begin
        a_r    <= operand_A;
        b_r    <= operand_B;
        mode_r <= subtract_mode;
      end
    end
  end

  assign a_s     = a_r;
  assign b_s     = b_r;
  assign mode_s  = mode_r;
  assign valid_s = valid_r;
`else
  assign a_s     = operand_A;
  assign b_s     = operand_B;
  assign mode_s  = subtract_mode;
  assign valid_s = in_valid;
`endif

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH:0]   result_next_s;
  logic             negative_next_s;
  logic             zero_next_s;

  // Ripple-carry chain; subtraction is A + ~B + 1, so the top bit flips carry into borrow.
  always_comb begin
    carry_s    = {(WIDTH+1){1'b0}};
    sum_s      = {WIDTH{1'b0}};
    carry_s[0] = mode_s;
    for (int i = 0; i < WIDTH; i++) begin
      {carry_s[i+1], sum_s[i]} = full_add(a_s[i], b_s[i] ^ mode_s, carry_s[i]);
    end
    result_next_s   = {carry_s[WIDTH] ^ mode_s, sum_s};
    negative_next_s = mode_s & result_next_s[WIDTH];
    zero_next_s     = (result_next_s == {(WIDTH+1){1'b0}});
  end

  logic [WIDTH:0] result_r;
  logic           out_valid_r;
  logic           negative_r;
  logic           zero_r;

  // Output register: reset wins over a valid op; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r    <= {(WIDTH+1){1'b0}};
      out_valid_r <= 1'b0;
      negative_r  <= 1'b0;
      zero_r      <= 1'b1;
    end else begin
      out_valid_r <= valid_s;
      if (valid_s) begin
        result_r   <= result_next_s;
        negative_r <= negative_next_s;
        zero_r     <= zero_next_s;
      end
    end
  end

  assign result    = result_r;
  assign out_valid = out_valid_r;
  assign negative  = negative_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_adder_subtractor_reg.sv
// Directed self-checking bench for adder_subtractor_reg (WIDTH=4); latency follows ADDSUB_PIPE_EN.
module tb_adder_subtractor_reg;

`ifdef ADDSUB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] operand_A;
  logic [3:0] operand_B;
  logic       subtract_mode;
  logic       in_valid;
  logic [4:0] result;
  logic       out_valid;
  logic       negative;
  logic       zero;

  // Observed tuple: {out_valid, negative, zero, result}
  logic [7:0] obs;
  assign obs = {out_valid, negative, zero, result};

  int pass_cnt  = 0;
  int total_cnt = 0;

  adder_subtractor_reg #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .operand_A(operand_A), .operand_B(operand_B),
    .subtract_mode(subtract_mode), .in_valid(in_valid), .result(result),
    .out_valid(out_valid), .negative(negative), .zero(zero)
  );

  always #5 clk = ~clk;

  // Drive one op for a single cycle, then idle until its result is visible (sampled on negedge).
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic m);
    @(negedge clk);
    operand_A = a; operand_B = b; subtract_mode = m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    operand_A = 4'd9; operand_B = 4'd4; subtract_mode = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (obs !== 8'b0010_0000) $display("FAIL reset_values: got %b expected %b", obs, 8'b0010_0000);
    else pass_cnt++;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== 8'b0010_0000) $display("FAIL reset_no_leak[%0d]: got %b expected %b", i, obs, 8'b0010_0000);
      else pass_cnt++;
    end
  endtask

  task automatic test_add();
    issue(4'd3, 4'd3, 1'b0);
    total_cnt++;
    if (obs !== {3'b100, 5'd6}) $display("FAIL add_3_3: got %b expected %b", obs, {3'b100, 5'd6});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL add_single_pulse: got %b expected 0", out_valid);
    else pass_cnt++;
    issue(4'd10, 4'd10, 1'b0);
    total_cnt++;
    if (obs !== {3'b100, 5'd20}) $display("FAIL add_10_10: got %b expected %b", obs, {3'b100, 5'd20});
    else pass_cnt++;
    issue(4'd15, 4'd15, 1'b0);
    total_cnt++;
    if (obs !== {3'b100, 5'd30}) $display("FAIL add_15_15: got %b expected %b", obs, {3'b100, 5'd30});
    else pass_cnt++;
  endtask

  task automatic test_subtract();
    issue(4'd7, 4'd2, 1'b1);
    total_cnt++;
    if (obs !== {3'b100, 5'd5}) $display("FAIL sub_7_2: got %b expected %b", obs, {3'b100, 5'd5});
    else pass_cnt++;
    issue(4'd5, 4'd10, 1'b1);
    total_cnt++;
    if (obs !== {3'b110, 5'b11011}) $display("FAIL sub_5_10: got %b expected %b", obs, {3'b110, 5'b11011});
    else pass_cnt++;
    issue(4'd0, 4'd15, 1'b1);
    total_cnt++;
    if (obs !== {3'b110, 5'b10001}) $display("FAIL sub_0_15: got %b expected %b", obs, {3'b110, 5'b10001});
    else pass_cnt++;
    issue(4'd9, 4'd9, 1'b1);
    total_cnt++;
    if (obs !== {3'b101, 5'd0}) $display("FAIL sub_9_9_zero: got %b expected %b", obs, {3'b101, 5'd0});
    else pass_cnt++;
  endtask

  task automatic test_hold();
    issue(4'd12, 4'd1, 1'b1);
    operand_A = 4'd15; operand_B = 4'd15; subtract_mode = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (obs !== {3'b000, 5'd11}) $display("FAIL hold_idle: got %b expected %b", obs, {3'b000, 5'd11});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] a_v [4];
    logic [3:0] b_v [4];
    logic       m_v [4];
    logic [7:0] e_v [4];
    a_v[0] = 4'd1;  b_v[0] = 4'd2;  m_v[0] = 1'b0; e_v[0] = {3'b100, 5'd3};
    a_v[1] = 4'd8;  b_v[1] = 4'd3;  m_v[1] = 1'b1; e_v[1] = {3'b100, 5'd5};
    a_v[2] = 4'd2;  b_v[2] = 4'd9;  m_v[2] = 1'b1; e_v[2] = {3'b110, 5'b11001};
    a_v[3] = 4'd12; b_v[3] = 4'd7;  m_v[3] = 1'b0; e_v[3] = {3'b100, 5'd19};
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      if (t >= LAT) begin
        total_cnt++;
        if (obs !== e_v[t-LAT]) $display("FAIL b2b_op%0d: got %b expected %b", t - LAT, obs, e_v[t-LAT]);
        else pass_cnt++;
      end
      if (t < 4) begin
        operand_A = a_v[t]; operand_B = b_v[t]; subtract_mode = m_v[t]; in_valid = 1'b1;
      end else begin
        rst = 1'b1; operand_A = 4'd15; operand_B = 4'd15; subtract_mode = 1'b0; in_valid = 1'b1;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (obs !== 8'b0010_0000) $display("FAIL b2b_reset: got %b expected %b", obs, 8'b0010_0000);
    else pass_cnt++;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== 8'b0010_0000) $display("FAIL b2b_discard[%0d]: got %b expected %b", i, obs, 8'b0010_0000);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_subtract();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/adder_subtractor_reg.md
# adder_subtractor_reg

Registered unsigned adder/subtractor for the board-level arithmetic demo path. It takes two WIDTH-bit switch operands and a mode bit, and produces a (WIDTH+1)-bit result that drives the LED bank. The result is the exact sum, or the two's-complement difference, of the zero-extended operands, so subtract results below zero wrap into the (WIDTH+1)-bit two's-complement range.

## Interface
- WIDTH, default 4: operand width in bits; minimum 2.
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: synchronous, active-high reset.
- operand_A  input  WIDTH: first operand, unsigned.
- operand_B  input  WIDTH: second operand, unsigned.
- subtract_mode  input  1: 0 = A+B, 1 = A−B.
- in_valid  input  1: operands and mode are sampled on a cycle where this is 1.
- result  output  WIDTH+1: registered result.
- out_valid  output  1: result holds a freshly computed value this cycle.
- negative  output  1: registered; 1 when subtract_mode was 1 and A<B.
- zero  output  1: registered; 1 when result is all zeros.

## Operation
- Datapath: ripple-carry chain of WIDTH full adders; B is XORed with subtract_mode and carry-in = subtract_mode.
- result[WIDTH−1:0] = chain sum bits.
- result[WIDTH] = carry_out XOR subtract_mode: carry for add, borrow (sign) for subtract.
- Add: result = A+B, range 0..2·(2^WIDTH−1); never overflows.
- Subtract: result = (A−B) mod 2^(WIDTH+1); interpreted as signed, range −(2^WIDTH−1)..2^WIDTH−1; never overflows.
- negative = subtract_mode AND result[WIDTH]; always 0 in add mode.
- zero = (result == 0).
- When in_valid = 0, result, negative and zero hold their previous values, and out_valid = 0 on the following cycle.
- No backpressure: every valid input produces exactly one out_valid pulse.

## Timing
- Base latency is 1 cycle: inputs sampled at edge N with in_valid = 1 give result, negative, zero and out_valid = 1 after edge N.
- Full throughput: one operation per cycle; back-to-back in_valid is accepted with no bubbles.
- Reset values: result = 0, out_valid = 0, negative = 0, zero = 1.
- Reset takes priority over in_valid in the same cycle; no operation sampled in a reset cycle is ever output.
- When reset is asserted while a result is in flight, including the pipeline stage, that result is discarded.

## Configuration
- ADDSUB_PIPE_EN defined: adds an input register stage for operand_A, operand_B, subtract_mode and in_valid.
  - Latency becomes 2 cycles; throughput is still 1 per cycle.
  - The stage's valid bit resets to 0.
- ADDSUB_PIPE_EN undefined: the combinational adder feeds the output register directly, with 1-cycle latency.
- Functional results are identical in both builds; only latency differs.

## Test plan
- A=3, B=3, mode=0, in_valid=1 -> result=5'b00110 (6), negative=0, zero=0, out_valid pulse after 1 cycle (2 with ADDSUB_PIPE_EN).
- A=7, B=2, mode=1 -> result=5'b00101 (5), negative=0.
- A=10, B=10, mode=0 -> result=5'b10100 (20); bit 4 is the carry, negative=0.
- A=5, B=10, mode=1 -> result=5'b11011 (−5 two's complement), negative=1; also A=0, B=15, mode=1 -> 5'b10001 (−15).
- A=9, B=9, mode=1 -> result=0, zero=1, negative=0; then A=15, B=15, mode=0 -> 5'b11110 (30).
- Back-to-back valid ops for 4 cycles, then rst asserted with in_valid=1 -> outputs go to their reset values on the next edge; the in-flight result and the operation sampled during reset never raise out_valid.
